rnd_pwm_fader: RTL

- Downstream consumer of the 16-bit random vector generator; drives the three LED pins (pin3/pin7/pin9 class outputs).
- Requests a new random word and splits it RGB565-style into three 8-bit brightness targets.
- Ramps each channel's PWM duty one LSB per step toward its target, dwells, then requests the next word.
- Replaces the free-running triangle "breathing" with random colour fades.

---
 rtl/rnd_pwm_fader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rnd_pwm_fader.sv
// Random colour fader: requests a 16-bit random word, splits it RGB565-style into
// three 8-bit brightness targets, ramps PWM duties toward them, dwells, and repeats.
module rnd_pwm_fader #(
  parameter int unsigned STEP_DIV = 32'd16,
  parameter int unsigned DWELL    = 32'd1000,
  parameter int unsigned RND_LAT  = 32'd1
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic [15:0] rnd_in,
  input  logic        hold,
  output logic        rnd_next,
  output logic [2:0]  pwm_out,
  output logic        busy
);

  localparam int DW_W  = $clog2(DWELL + 32'd1);
  localparam int LAT_W = $clog2(RND_LAT + 32'd1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_RAMP  = 3'd4,
    S_DWELL = 3'd5
  } state_t;

  state_t          state_r;
  logic [7:0]      pwm_cnt_r;
  logic [2:0][7:0] duty_r;
  logic [2:0][7:0] tgt_r;
  logic [15:0]     presc_r;
  logic [DW_W-1:0] dwell_cnt_r;
  logic [LAT_W-1:0] lat_cnt_r;
  logic            presc_wrap_s;
  logic            all_eq_s;

  // Moves one LSB toward the target, saturating at the target itself.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // RGB565 expansion: replicate the top bits of each field into the low bits.
  function automatic logic [2:0][7:0] split_targets(input logic [15:0] w);
    return {{w[4:0], w[4:2]}, {w[10:5], w[10:9]}, {w[15:11], w[15:13]}};
  endfunction

  // Prescaler wrap and ramp-complete detection.
  always_comb begin
    presc_wrap_s = (presc_r == 16'(STEP_DIV - 32'd1));
    all_eq_s     = (duty_r == tgt_r);
  end

  // Free-running PWM counter and registered comparators.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= 8'd0;
      pwm_out   <= 3'b000;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
      for (int i = 0; i < 3; i++) begin
        pwm_out[i] <= (pwm_cnt_r < duty_r[i]);
      end
    end
  end

  // Sequencer: request, load, ramp and dwell, with registered rnd_next/busy.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      duty_r      <= '0;
      tgt_r       <= '0;
      presc_r     <= 16'd0;
      dwell_cnt_r <= '0;
      lat_cnt_r   <= '0;
      rnd_next    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r  <= S_REQ;
          rnd_next <= 1'b1;
          busy     <= 1'b1;
        end
        S_REQ: begin
          state_r   <= S_WAIT;
          rnd_next  <= 1'b0;
          lat_cnt_r <= '0;
        end
        S_WAIT: begin
          if (lat_cnt_r == LAT_W'(RND_LAT - 32'd1)) begin
            state_r <= S_LOAD;
          end else begin
            lat_cnt_r <= lat_cnt_r + 1'b1;
          end
        end
        S_LOAD: begin
          tgt_r   <= split_targets(rnd_in);
          presc_r <= 16'd0;
          state_r <= S_RAMP;
        end
        S_RAMP: begin
          if (all_eq_s) begin
            state_r     <= S_DWELL;
            dwell_cnt_r <= '0;
            presc_r     <= 16'd0;
            busy        <= 1'b0;
          end else if (!hold) begin
            if (presc_wrap_s) begin
              presc_r <= 16'd0;
              for (int i = 0; i < 3; i++) begin
                duty_r[i] <= step_toward(duty_r[i], tgt_r[i]);
              end
            end else begin
              presc_r <= presc_r + 16'd1;
            end
          end
        end
        S_DWELL: begin
          if (!hold) begin
            if (presc_wrap_s) begin
              presc_r <= 16'd0;
              if (dwell_cnt_r == DW_W'(DWELL - 32'd1)) begin
                state_r  <= S_REQ;
                rnd_next <= 1'b1;
                busy     <= 1'b1;
              end else begin
                dwell_cnt_r <= dwell_cnt_r + 1'b1;
              end
            end else begin
              presc_r <= presc_r + 16'd1;
            end
          end
        end
        default: begin
          state_r  <= S_IDLE;
          rnd_next <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
